// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: time-multiplexed scan controller for a shared-decoder seven-segment display
//   load/load_data/load_ready : valid/ready handshake for a packed BCD word, committed at frame end
//   blank_lz                  : suppress enables of leading zero digits (digit 0 always lit)
//   bcd_out/digit_en          : BCD code to the shared decoder and one-hot digit select
//   frame_done                : one-cycle pulse in the final lit cycle of the last digit
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int BLANK_GAP   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  input  logic                    blank_lz,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);
  localparam int MAXC = REFRESH_DIV > BLANK_GAP ? REFRESH_DIV : BLANK_GAP;
  localparam int CW   = MAXC > 1 ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(NUM_DIGITS);
  typedef enum logic {BLANK, SHOW} state_t;
  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [IW-1:0]           idx, idx_n;
  logic [4*NUM_DIGITS-1:0] display, display_n, shadow;
  logic                    pending, pending_n, fire, last, xfer, supp, z;
  logic [NUM_DIGITS-1:0]   zero_above;
  always_comb begin
    fire      = state == SHOW && idx == IW'(NUM_DIGITS-1) && cnt == CW'(REFRESH_DIV-1);
    last      = state == SHOW ? cnt == CW'(REFRESH_DIV-1) : cnt == CW'(BLANK_GAP-1);
    xfer      = load && load_ready;
    state_n   = last ? (state == SHOW ? BLANK : SHOW) : state;
    cnt_n     = last ? '0 : cnt + 1'b1;
    idx_n     = last && state == SHOW ? (idx == IW'(NUM_DIGITS-1) ? '0 : idx + 1'b1) : idx;
    display_n = fire && pending ? shadow : display;
    pending_n = xfer || (pending && !fire);
    z         = 1'b1;
    zero_above = '0;
    for (int i = NUM_DIGITS-1; i >= 0; i--) begin
      z = z && display_n[4*i +: 4] == 4'd0;
      zero_above[i] = z;
    end
    supp = blank_lz && idx_n != '0 && zero_above[idx_n];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= '0;
      display    <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      load_ready <= 1'b1;
      bcd_out    <= 4'd0;
      digit_en   <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      display    <= display_n;
      shadow     <= xfer ? load_data : shadow;
      pending    <= pending_n;
      load_ready <= !pending_n;
      bcd_out    <= display_n[{idx_n, 2'b00} +: 4];
      digit_en   <= state_n == SHOW && !supp ? NUM_DIGITS'(1) << idx_n : '0;
      frame_done <= state_n == SHOW && idx_n == IW'(NUM_DIGITS-1) && cnt_n == CW'(REFRESH_DIV-1);
    end
  end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: directed self-checking bench for seven_seg_scan_ctrl
module tb_seven_seg_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst, load, load_ready, blank_lz, frame_done;
  logic [15:0] load_data, disp;
  logic [3:0]  bcd_out, digit_en, mask, exp_en, exp_bcd;
  logic [3:0]  obs_en[20], obs_bcd[20];
  logic        obs_fd[20], obs_rdy[20];
  int          checks = 0, errors = 0;
  seven_seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_GAP(1)) dut (
    .clk(clk), .rst(rst), .load(load), .load_data(load_data), .load_ready(load_ready),
    .blank_lz(blank_lz), .bcd_out(bcd_out), .digit_en(digit_en), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired got no finish exp finish");
    $fatal(1);
  end
  task automatic grab_frame;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      load = 1'b0;
      obs_en[c] = digit_en;
      obs_bcd[c] = bcd_out;
      obs_fd[c] = frame_done;
      obs_rdy[c] = load_ready;
    end
  endtask
  task automatic wait_fd(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = frame_done;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s frame_done got none in 60 cycles exp pulse", tag);
    end
  endtask
  task automatic do_load(input logic [15:0] d);
    @(negedge clk);
    for (int i = 0; i < 60 && !load_ready; i++) @(negedge clk);
    load = 1'b1;
    load_data = d;
    @(negedge clk);
    load = 1'b0;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (digit_en !== 4'b0 || bcd_out !== 4'd0 || load_ready !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got en=%b bcd=%h rdy=%b fd=%b exp 0000 0 1 0", digit_en, bcd_out, load_ready, frame_done);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (digit_en !== 4'b0) begin
      errors++;
      $display("FAIL reset_blank got en=%b exp 0000", digit_en);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (digit_en !== 4'b0001 || bcd_out !== 4'd0) begin
        errors++;
        $display("FAIL reset_show%0d got en=%b bcd=%h exp 0001 0", k, digit_en, bcd_out);
      end
    end
    @(negedge clk);
    checks++;
    if (digit_en !== 4'b0) begin
      errors++;
      $display("FAIL reset_gap1 got en=%b exp 0000", digit_en);
    end
  endtask
  task automatic test_scan;
    blank_lz = 1'b0;
    do_load(16'h1234);
    wait_fd("scan_commit");
    grab_frame;
    disp = 16'h1234;
    mask = 4'hF;
    for (int c = 0; c < 20; c++) begin
      exp_en = (c % 5 == 0 || !mask[c/5]) ? 4'b0 : 4'b1 << (c/5);
      exp_bcd = disp[4*(c/5) +: 4];
      checks++;
      if (obs_en[c] !== exp_en || obs_bcd[c] !== exp_bcd || obs_fd[c] !== (c == 19) || obs_rdy[c] !== 1'b1) begin
        errors++;
        $display("FAIL scan c=%0d got en=%b bcd=%h fd=%b rdy=%b exp en=%b bcd=%h fd=%b rdy=1",
                 c, obs_en[c], obs_bcd[c], obs_fd[c], obs_rdy[c], exp_en, exp_bcd, c == 19);
      end
    end
  endtask
  task automatic test_handshake;
    do_load(16'h5678);
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL hs_ready_drop got %b exp 0", load_ready);
    end
    load = 1'b1;
    load_data = 16'h9999;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (load_ready !== 1'b0 || bcd_out !== 4'd4) begin
      errors++;
      $display("FAIL hs_ignored got rdy=%b bcd=%h exp 0 4", load_ready, bcd_out);
    end
    wait_fd("hs_commit");
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL hs_ready_at_fd got %b exp 0", load_ready);
    end
    grab_frame;
    disp = 16'h5678;
    mask = 4'hF;
    for (int c = 0; c < 20; c++) begin
      exp_en = (c % 5 == 0 || !mask[c/5]) ? 4'b0 : 4'b1 << (c/5);
      exp_bcd = disp[4*(c/5) +: 4];
      checks++;
      if (obs_en[c] !== exp_en || obs_bcd[c] !== exp_bcd || obs_rdy[c] !== 1'b1) begin
        errors++;
        $display("FAIL hs c=%0d got en=%b bcd=%h rdy=%b exp en=%b bcd=%h rdy=1",
                 c, obs_en[c], obs_bcd[c], obs_rdy[c], exp_en, exp_bcd);
      end
    end
    grab_frame;
    checks++;
    if (obs_bcd[0] !== 4'd8 || obs_bcd[15] !== 4'd5) begin
      errors++;
      $display("FAIL hs_no_queue got bcd0=%h bcd3=%h exp 8 5", obs_bcd[0], obs_bcd[15]);
    end
  endtask
  task automatic test_leading_zeros;
    blank_lz = 1'b1;
    do_load(16'h0070);
    wait_fd("lz_commit");
    grab_frame;
    disp = 16'h0070;
    mask = 4'b0011;
    for (int c = 0; c < 20; c++) begin
      exp_en = (c % 5 == 0 || !mask[c/5]) ? 4'b0 : 4'b1 << (c/5);
      exp_bcd = disp[4*(c/5) +: 4];
      checks++;
      if (obs_en[c] !== exp_en || obs_bcd[c] !== exp_bcd) begin
        errors++;
        $display("FAIL lz_on c=%0d got en=%b bcd=%h exp en=%b bcd=%h", c, obs_en[c], obs_bcd[c], exp_en, exp_bcd);
      end
    end
    blank_lz = 1'b0;
    grab_frame;
    mask = 4'hF;
    for (int c = 0; c < 20; c++) begin
      exp_en = (c % 5 == 0 || !mask[c/5]) ? 4'b0 : 4'b1 << (c/5);
      checks++;
      if (obs_en[c] !== exp_en) begin
        errors++;
        $display("FAIL lz_off c=%0d got en=%b exp en=%b", c, obs_en[c], exp_en);
      end
    end
    blank_lz = 1'b1;
    do_load(16'h0000);
    wait_fd("lz_zero_commit");
    grab_frame;
    mask = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      exp_en = (c % 5 == 0 || !mask[c/5]) ? 4'b0 : 4'b1 << (c/5);
      checks++;
      if (obs_en[c] !== exp_en || obs_bcd[c] !== 4'd0) begin
        errors++;
        $display("FAIL lz_zero c=%0d got en=%b bcd=%h exp en=%b bcd=0", c, obs_en[c], obs_bcd[c], exp_en);
      end
    end
  endtask
  task automatic test_boundary;
    blank_lz = 1'b0;
    load = 1'b1;
    load_data = 16'h4321;
    grab_frame;
    mask = 4'hF;
    for (int c = 0; c < 20; c++) begin
      exp_en = (c % 5 == 0 || !mask[c/5]) ? 4'b0 : 4'b1 << (c/5);
      checks++;
      if (obs_en[c] !== exp_en || obs_bcd[c] !== 4'd0 || obs_rdy[c] !== 1'b0) begin
        errors++;
        $display("FAIL bnd_old c=%0d got en=%b bcd=%h rdy=%b exp en=%b bcd=0 rdy=0", c, obs_en[c], obs_bcd[c], obs_rdy[c], exp_en);
      end
    end
    grab_frame;
    disp = 16'h4321;
    for (int c = 0; c < 20; c++) begin
      exp_bcd = disp[4*(c/5) +: 4];
      checks++;
      if (obs_bcd[c] !== exp_bcd || obs_rdy[c] !== 1'b1) begin
        errors++;
        $display("FAIL bnd_new c=%0d got bcd=%h rdy=%b exp bcd=%h rdy=1", c, obs_bcd[c], obs_rdy[c], exp_bcd);
      end
    end
  endtask
  task automatic test_passthrough;
    blank_lz = 1'b1;
    do_load(16'hF00A);
    wait_fd("pass_commit");
    grab_frame;
    disp = 16'hF00A;
    mask = 4'hF;
    for (int c = 0; c < 20; c++) begin
      exp_en = (c % 5 == 0 || !mask[c/5]) ? 4'b0 : 4'b1 << (c/5);
      exp_bcd = disp[4*(c/5) +: 4];
      checks++;
      if (obs_en[c] !== exp_en || obs_bcd[c] !== exp_bcd) begin
        errors++;
        $display("FAIL pass c=%0d got en=%b bcd=%h exp en=%b bcd=%h", c, obs_en[c], obs_bcd[c], exp_en, exp_bcd);
      end
    end
  endtask
  task automatic test_reset_mid;
    do_load(16'hBEEF);
    for (int i = 0; i < 40 && digit_en !== 4'b0001; i++) @(negedge clk);
    checks++;
    if (digit_en !== 4'b0001 || bcd_out !== 4'hA || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_pre got en=%b bcd=%h rdy=%b exp 0001 a 0", digit_en, bcd_out, load_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (digit_en !== 4'b0 || bcd_out !== 4'd0 || load_ready !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async got en=%b bcd=%h rdy=%b fd=%b exp 0000 0 1 0", digit_en, bcd_out, load_ready, frame_done);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (digit_en !== 4'b0) begin
      errors++;
      $display("FAIL rstmid_blank got en=%b exp 0000", digit_en);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (digit_en !== 4'b0001 || bcd_out !== 4'd0) begin
        errors++;
        $display("FAIL rstmid_show%0d got en=%b bcd=%h exp 0001 0", k, digit_en, bcd_out);
      end
    end
    wait_fd("rstmid_fd");
    grab_frame;
    mask = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      exp_en = (c % 5 == 0 || !mask[c/5]) ? 4'b0 : 4'b1 << (c/5);
      checks++;
      if (obs_en[c] !== exp_en || obs_bcd[c] !== 4'd0 || obs_rdy[c] !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_discard c=%0d got en=%b bcd=%h rdy=%b exp en=%b bcd=0 rdy=1", c, obs_en[c], obs_bcd[c], obs_rdy[c], exp_en);
      end
    end
  endtask
  initial begin
    rst = 1'b1;
    load = 1'b0;
    load_data = 16'h0;
    blank_lz = 1'b0;
    test_reset;
    test_scan;
    test_handshake;
    test_leading_zeros;
    test_boundary;
    test_passthrough;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
